// File: rtl/branch_cmp_pkg.sv
// branch_cmp_pkg
//   Shared constants for the branch flag comparator:
//     - FSM state encodings (1-bit, legacy-compatible localparams)
//     - bit positions of igual/maior/menor inside the packed flag vector
//     - decide_flags(): turns a slice eq/gt result into the one-hot flag vector
package branch_cmp_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_CMP  = 1'b1;

    localparam int FLAG_IGUAL = 0;
    localparam int FLAG_MAIOR = 1;
    localparam int FLAG_MENOR = 2;

    // Exactly one bit set: equal wins, otherwise greater, otherwise less.
    function automatic logic [2:0] decide_flags(input logic eq, input logic gt);
        logic [2:0] f;
        f = '0;
        if (eq)      f[FLAG_IGUAL] = 1'b1;
        else if (gt) f[FLAG_MAIOR] = 1'b1;
        else         f[FLAG_MENOR] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/branch_flag_compare_slice_cmp.sv
// slice_cmp
//   Combinational unsigned compare of one CHUNK-bit operand slice.
//   Ports:
//     a, b  in  CHUNK  slice of operand A / operand B
//     eq    out 1      a == b
//     gt    out 1      a >  b (unsigned)
module slice_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             gt
);

    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/branch_flag_compare.sv
// branch_flag_compare
//   Iterative operand comparator feeding branch select. A and B are compared
//   CHUNK bits per cycle, most significant slice first, stopping at the first
//   slice that differs. The compare is signed: the sign bit of both operands
//   is inverted at capture, which turns a signed order into an unsigned one,
//   so every slice can then use the same unsigned slice_cmp.
//
//   Optional feature (macro BRANCH_CMP_UNSIGNED_EN): adds input is_unsigned,
//   captured with the operands; when 1 the sign-bit inversion is skipped and
//   the compare is pure unsigned. Without the macro the compare is always signed.
//
//   Ports:
//     clk          in   1      rising-edge clock
//     reset_n      in   1      asynchronous active-low reset
//     start        in   1      compare request, sampled only while idle
//     a, b         in   WIDTH  operands, captured on the accepting edge
//     is_unsigned  in   1      (BRANCH_CMP_UNSIGNED_EN only) unsigned compare
//     busy         out  1      compare in flight
//     done         out  1      one-cycle pulse, flags valid from this cycle on
//     igual/maior/menor out 1  A==B / A>B / A<B, held until the next decision
//
//   Handshake: start is a request that is accepted on any rising edge where
//   the block is idle (busy=0), including the cycle in which done is high.
//   While busy=1 start is ignored. Each accepted start yields exactly one done
//   pulse, 1..NS edges later; done and busy are never high together.
//
//   The FSM state is available as the internal signal 'state' (ST_IDLE/ST_CMP).
module branch_flag_compare
    import branch_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef BRANCH_CMP_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic             busy,
    output logic             done,
    output logic             igual,
    output logic             maior,
    output logic             menor
);

    localparam int NS = WIDTH / CHUNK;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0]    IDX_TOP   = IW'(NS - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("branch_flag_compare: WIDTH must be a multiple of CHUNK");
    end

    logic                      state;
    logic [IW-1:0]             idx;
    logic [NS-1:0][CHUNK-1:0]  a_q;
    logic [NS-1:0][CHUNK-1:0]  b_q;
    logic [2:0]                flags_q;

    logic [WIDTH-1:0]          cap_mask;
    logic [CHUNK-1:0]          a_slice;
    logic [CHUNK-1:0]          b_slice;
    logic                      slice_eq;
    logic                      slice_gt;

    // Sign-bit inversion is folded into the capture, so the stored operands
    // already compare correctly as unsigned values.
`ifdef BRANCH_CMP_UNSIGNED_EN
    assign cap_mask = is_unsigned ? '0 : SIGN_MASK;
`else
    assign cap_mask = SIGN_MASK;
`endif

    assign a_slice = a_q[idx];
    assign b_slice = b_q[idx];

    slice_cmp #(
        .CHUNK (CHUNK)
    ) u_slice_cmp (
        .a  (a_slice),
        .b  (b_slice),
        .eq (slice_eq),
        .gt (slice_gt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            idx     <= IDX_TOP;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    a_q   <= a ^ cap_mask;
                    b_q   <= b ^ cap_mask;
                    idx   <= IDX_TOP;
                    busy  <= 1'b1;
                    state <= ST_CMP;
                end
            end else begin
                // A differing slice decides immediately; equal slices walk
                // down until slice 0, where equality decides the result.
                if (!slice_eq || idx == '0) begin
                    flags_q <= decide_flags(slice_eq, slice_gt);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

    assign igual = flags_q[FLAG_IGUAL];
    assign maior = flags_q[FLAG_MAIOR];
    assign menor = flags_q[FLAG_MENOR];

endmodule

// File: tb/tb_branch_flag_compare.sv
module tb_branch_flag_compare;

    localparam logic [2:0] EQ = 3'b001;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b100;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        uns;
        logic [2:0]  exp_flags;
        int          exp_lat;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        is_unsigned = 1'b0;
    logic        busy, done, igual, maior, menor;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    branch_flag_compare #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .a           (a),
        .b           (b),
`ifdef BRANCH_CMP_UNSIGNED_EN
        .is_unsigned (is_unsigned),
`endif
        .busy        (busy),
        .done        (done),
        .igual       (igual),
        .maior       (maior),
        .menor       (menor)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] flags_now();
        return {menor, maior, igual};
    endfunction

    // ---------------- driver tasks ----------------
    // One compare: start pulse, scramble operands after capture, wait (bounded)
    // for done, then confirm the pulse is one cycle wide.
    task automatic run_vec(input vec_t v);
        int lat;
        bit got;
        @(negedge clk);
        a = v.a;
        b = v.b;
        is_unsigned = v.uns;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({v.name, ".busy_after_accept"}, busy, 1);
        a = $urandom;
        b = $urandom;
        is_unsigned = 1'($urandom_range(0, 1));
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) got = 1;
        end
        check({v.name, ".done_seen"}, got, 1);
        check({v.name, ".latency"}, lat, v.exp_lat);
        check({v.name, ".flags"}, flags_now(), v.exp_flags);
        check({v.name, ".busy_at_done"}, busy, 0);
        @(posedge clk);
        #1;
        check({v.name, ".done_one_cycle"}, done, 0);
    endtask

    initial begin
        int ndone;
        int lat;
        int nbusy;

        // ---------------- vector table ----------------
        vecs.push_back('{32'h0000_0005, 32'h0000_0005, 1'b0, EQ, 4, "eq5"});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, LT, 1, "min_vs_1"});
        vecs.push_back('{32'h1234_5679, 32'h1234_5678, 1'b0, GT, 4, "lsb_gt"});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, LT, 1, "neg1_vs_0"});
        vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, GT, 1, "max_vs_min"});
        vecs.push_back('{32'h0012_3400, 32'h0012_3500, 1'b0, LT, 3, "slice1_lt"});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, EQ, 4, "zero_eq"});
        vecs.push_back('{32'h8000_0001, 32'h8000_0000, 1'b0, GT, 4, "neg_lsb_gt"});
        vecs.push_back('{32'hFFFF_FF00, 32'hFFFF_FF01, 1'b0, LT, 4, "neg_lsb_lt"});
`ifdef BRANCH_CMP_UNSIGNED_EN
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, GT, 1, "u_min_vs_1"});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, GT, 1, "u_neg1_vs_0"});
        vecs.push_back('{32'h0012_3400, 32'h0012_3500, 1'b1, LT, 3, "u_slice1_lt"});
`endif

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        check("in_reset.busy", busy, 0);
        check("in_reset.done", done, 0);
        check("in_reset.flags", flags_now(), 3'b000);
        @(negedge clk);
        reset_n = 1'b1;
        nbusy = 0;
        ndone = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (busy) nbusy++;
            if (done) ndone++;
        end
        check("idle.busy_count", nbusy, 0);
        check("idle.done_count", ndone, 0);
        check("idle.flags", flags_now(), 3'b000);

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) run_vec(vecs[i]);

        // ---------------- start while busy is ignored ----------------
        @(negedge clk);
        a = 32'h1234_5679;
        b = 32'h1234_5678;
        is_unsigned = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        a = 32'h0;
        b = 32'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        lat = 0;
        for (int n = 2; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    lat = n;
                    check("busy_start.flags", flags_now(), GT);
                end
            end
        end
        check("busy_start.done_count", ndone, 1);
        check("busy_start.latency", lat, 4);
        check("busy_start.idle_after", busy, 0);

        // ---------------- reset mid-compare ----------------
        @(negedge clk);
        a = 32'hFF00_0000;
        b = 32'h0100_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mid_reset.busy_before", busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_reset.busy", busy, 0);
        check("mid_reset.done", done, 0);
        check("mid_reset.flags", flags_now(), 3'b000);
        ndone = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("mid_reset.no_done", ndone, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_vec('{32'h0000_0000, 32'h0000_0000, 1'b0, EQ, 4, "restart_eq"});

        // ---------------- back-to-back, start held across done ----------------
        @(negedge clk);
        a = 32'h8000_0000;
        b = 32'h0000_0001;
        is_unsigned = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("b2b.busy_first", busy, 1);
        a = 32'h0000_0003;
        b = 32'h0000_0003;
        @(posedge clk);
        #1;
        check("b2b.done_first", done, 1);
        check("b2b.flags_first", flags_now(), LT);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b.second_accepted", busy, 1);
        check("b2b.done_low", done, 0);
        check("b2b.flags_hold0", flags_now(), LT);
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b.flags_hold%0d", n), flags_now(), LT);
            check($sformatf("b2b.no_done%0d", n), done, 0);
        end
        @(posedge clk);
        #1;
        check("b2b.done_second", done, 1);
        check("b2b.flags_second", flags_now(), EQ);
        @(posedge clk);
        #1;
        check("b2b.done_one_cycle", done, 0);
        check("b2b.idle", busy, 0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
